// File: rtl/two_five_pkg.sv
// Shared constants and types for the serial 2-of-5 receiver: legal code words,
// the invalid-digit marker, word length and the receive FSM state type.
package two_five_pkg;

    localparam int WORD_BITS = 5;
    localparam logic [3:0] DIG_INVALID = 4'hF;

    // Legal 2-of-5 code words, bit 4 (first on the wire) on the left.
    localparam logic [WORD_BITS-1:0] CODE_0 = 5'b01100;
    localparam logic [WORD_BITS-1:0] CODE_1 = 5'b11000;
    localparam logic [WORD_BITS-1:0] CODE_2 = 5'b10100;
    localparam logic [WORD_BITS-1:0] CODE_3 = 5'b10010;
    localparam logic [WORD_BITS-1:0] CODE_4 = 5'b01010;
    localparam logic [WORD_BITS-1:0] CODE_5 = 5'b00110;
    localparam logic [WORD_BITS-1:0] CODE_6 = 5'b10001;
    localparam logic [WORD_BITS-1:0] CODE_7 = 5'b01001;
    localparam logic [WORD_BITS-1:0] CODE_8 = 5'b00101;
    localparam logic [WORD_BITS-1:0] CODE_9 = 5'b00011;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic       err;
        logic [3:0] digit;
    } dec_t;

endpackage

// File: rtl/two_five_dec_ser_if.sv
// Serial-in / digit-out handshake bundle of the 2-of-5 receiver.
// master = link driver plus digit consumer, slave = the receiver.
interface two_five_dec_ser_if;

    logic       sin;
    logic       sin_valid;
    logic       sin_sof;
    logic       sin_ready;
    logic [3:0] dout;
    logic       dout_err;
    logic       dout_valid;
    logic       dout_ready;

    modport master (
        output sin, sin_valid, sin_sof, dout_ready,
        input  sin_ready, dout, dout_err, dout_valid
    );

    modport slave (
        input  sin, sin_valid, sin_sof, dout_ready,
        output sin_ready, dout, dout_err, dout_valid
    );

endinterface

// File: rtl/two_five_dec_lut.sv
// Combinational 2-of-5 code to BCD decode; any non-legal pattern yields
// DIG_INVALID with err set.
module two_five_dec_lut
    import two_five_pkg::*;
(
    input  logic [WORD_BITS-1:0] code,
    output dec_t                 dec
);

    // NOTE: default assignment first so every path drives dec and no latch is inferred.
    always_comb begin
        dec = '{err: 1'b1, digit: DIG_INVALID};
        case (code)
            CODE_0: dec = '{err: 1'b0, digit: 4'd0};
            CODE_1: dec = '{err: 1'b0, digit: 4'd1};
            CODE_2: dec = '{err: 1'b0, digit: 4'd2};
            CODE_3: dec = '{err: 1'b0, digit: 4'd3};
            CODE_4: dec = '{err: 1'b0, digit: 4'd4};
            CODE_5: dec = '{err: 1'b0, digit: 4'd5};
            CODE_6: dec = '{err: 1'b0, digit: 4'd6};
            CODE_7: dec = '{err: 1'b0, digit: 4'd7};
            CODE_8: dec = '{err: 1'b0, digit: 4'd8};
            CODE_9: dec = '{err: 1'b0, digit: 4'd9};
            default: ;
        endcase
    end

endmodule

// File: rtl/two_five_dec_ser.sv
// Serial 2-of-5 receiver: frames words on sin_sof, decodes to BCD into a
// one-entry valid/ready output register. Define TWO_FIVE_DEC_ERRCNT_EN to build
// the saturating code/framing error counter; otherwise err_cnt is tied to zero.
module two_five_dec_ser
    import two_five_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    two_five_dec_ser_if.slave    bus,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam logic [2:0] LAST_BIT = 3'(WORD_BITS - 1);

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-2:0]   shift_q, shift_d;
    logic [3:0]             dout_q, dout_d;
    logic                   dout_err_q, dout_err_d;
    logic                   dout_valid_q, dout_valid_d;

    logic                   sin_ready;
    logic                   accept;
    logic                   err_ev;
    logic [WORD_BITS-1:0]   word_nxt;
    dec_t                   dec;

    // Only the last bit of a word can stall, and only on registered state.
    assign sin_ready = ~(dout_valid_q & (state_q == SHIFT) & (bit_cnt_q == LAST_BIT));
    assign accept    = bus.sin_valid & sin_ready;
    assign word_nxt  = {shift_q, bus.sin};

    two_five_dec_lut u_lut (
        .code (word_nxt),
        .dec  (dec)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_err_d   = dout_err_q;
        dout_valid_d = dout_valid_q;
        err_ev       = 1'b0;

        if (dout_valid_q && bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (accept) begin
            if (bus.sin_sof) begin
                // A sof inside a word drops the partial word and restarts framing.
                err_ev    = (state_q == SHIFT);
                shift_d   = {{(WORD_BITS-2){1'b0}}, bus.sin};
                bit_cnt_d = 3'd1;
                state_d   = SHIFT;
            end else if (state_q == SHIFT) begin
                shift_d = word_nxt[WORD_BITS-2:0];
                if (bit_cnt_q == LAST_BIT) begin
                    dout_d       = dec.digit;
                    dout_err_d   = dec.err;
                    dout_valid_d = 1'b1;
                    err_ev       = dec.err;
                    bit_cnt_d    = 3'd0;
                    state_d      = HUNT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= 3'd0;
            shift_q      <= '0;
            dout_q       <= 4'd0;
            dout_err_q   <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_err_q   <= dout_err_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.sin_ready  = sin_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_err   = dout_err_q;
    assign bus.dout_valid = dout_valid_q;

`ifdef TWO_FIVE_DEC_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_ev && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_ev;
    assign unused_err_ev = err_ev;
    assign err_cnt       = '0;
`endif

endmodule

// File: tb/tb_two_five_dec_ser.sv
// Bench for two_five_dec_ser: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based word model.
module tb_two_five_dec_ser;

`ifdef TWO_FIVE_DEC_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    two_five_dec_ser_if sif ();
    two_five_dec_ser_if sif2 ();

    assign sif2.sin        = sif.sin;
    assign sif2.sin_valid  = sif.sin_valid;
    assign sif2.sin_sof    = sif.sin_sof;
    assign sif2.dout_ready = sif.dout_ready;

    two_five_dec_ser #(.ERR_W(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (sif.slave),
        .err_cnt (err_cnt)
    );

    two_five_dec_ser #(.ERR_W(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (sif2.slave),
        .err_cnt (err_cnt2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of received bits per word, decoded by table search.
    logic [4:0] legal [10] = '{5'b01100, 5'b11000, 5'b10100, 5'b10010, 5'b01010,
                               5'b00110, 5'b10001, 5'b01001, 5'b00101, 5'b00011};

    function automatic int decode(input logic [4:0] w);
        int d = -1;
        for (int i = 0; i < 10; i++) if (legal[i] == w) d = i;
        return d;
    endfunction

    bit         m_q[$];
    bit         m_valid = 1'b0;
    logic [3:0] m_dout  = 4'd0;
    bit         m_err   = 1'b0;
    int         m_ecnt  = 0;

    function automatic bit m_ready();
        return !(m_valid && m_q.size() == 4);
    endfunction

    always @(posedge clk) begin : model
        logic [4:0] w;
        int         d;
        bit         acc;
        if (rst) begin
            m_q.delete();
            m_valid = 1'b0;
            m_dout  = 4'd0;
            m_err   = 1'b0;
            m_ecnt  = 0;
        end else begin
            acc = sif.sin_valid && m_ready();
            if (m_valid && sif.dout_ready) m_valid = 1'b0;
            if (acc) begin
                if (sif.sin_sof) begin
                    if (m_q.size() > 0) m_ecnt++;
                    m_q.delete();
                    m_q.push_back(sif.sin);
                end else if (m_q.size() > 0) begin
                    m_q.push_back(sif.sin);
                    if (m_q.size() == 5) begin
                        w = {m_q[0], m_q[1], m_q[2], m_q[3], m_q[4]};
                        d = decode(w);
                        m_valid = 1'b1;
                        if (d < 0) begin
                            m_dout = 4'hF;
                            m_err  = 1'b1;
                            m_ecnt++;
                        end else begin
                            m_dout = 4'(d);
                            m_err  = 1'b0;
                        end
                        m_q.delete();
                    end
                end
            end
        end
    end

    function automatic int exp_err(input int n, input int maxv);
        if (!ERRCNT_EN) return 0;
        return (n > maxv) ? maxv : n;
    endfunction

    // Compare process: outputs checked on the falling edge every cycle.
    bit         chk_en = 1'b0;
    logic [4:0] got[$];
    int         vld_cycles = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("sin_ready",  {31'd0, sif.sin_ready},  {31'd0, m_ready()});
            check("dout_valid", {31'd0, sif.dout_valid}, {31'd0, m_valid});
            check("dout",       {28'd0, sif.dout},       {28'd0, m_dout});
            check("dout_err",   {31'd0, sif.dout_err},   {31'd0, m_err});
            check("err_cnt",    {24'd0, err_cnt},        32'(exp_err(m_ecnt, 255)));
            check("err_cnt_w2", {30'd0, err_cnt2},       32'(exp_err(m_ecnt, 3)));
            if (sif.dout_valid) vld_cycles++;
            if (sif.dout_valid && sif.dout_ready) got.push_back({sif.dout_err, sif.dout});
        end
    end

    bit rdy_rand = 1'b0;
    always @(posedge clk) begin
        if (rdy_rand) begin
            #2;
            sif.dout_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_bit(input logic b, input logic sof);
        bit done = 1'b0;
        sif.sin       = b;
        sif.sin_sof   = sof;
        sif.sin_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sif.sin_ready) done = 1'b1;
            @(posedge clk);
            #2;
        end
        check("accept_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic send_word(input logic [4:0] code);
        for (int i = 4; i >= 0; i--) send_bit(code[i], i == 4);
    endtask

    task automatic idle(input int n);
        sif.sin_valid = 1'b0;
        sif.sin_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.sin = 1'b0;
        sif.sin_valid = 1'b0;
        sif.sin_sof = 1'b0;
        sif.dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        rst = 1'b0;
        check("rst_valid", {31'd0, sif.dout_valid}, 32'd0);
        check("rst_ready", {31'd0, sif.sin_ready}, 32'd1);
        check("rst_dout",  {28'd0, sif.dout}, 32'd0);

        // All ten legal codes back-to-back.
        got.delete();
        vld_cycles = 0;
        for (int i = 0; i < 10; i++) send_word(legal[i]);
        idle(3);
        check("legal_count", got.size(), 10);
        check("legal_pulses", vld_cycles, 10);
        for (int i = 0; i < got.size(); i++) check("legal_digit", {27'd0, got[i]}, 32'(i));
        check("legal_errcnt", {24'd0, err_cnt}, 32'd0);

        // Invalid codes.
        got.delete();
        send_word(5'b11011);
        send_word(5'b00000);
        idle(3);
        check("inv_count", got.size(), 2);
        for (int i = 0; i < got.size(); i++) check("inv_word", {27'd0, got[i]}, 32'h1F);
        check("inv_errcnt", {24'd0, err_cnt}, ERRCNT_EN ? 32'd2 : 32'd0);

        // Framing error: three bits of 10010, then sof-framed 01010.
        got.delete();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_word(5'b01010);
        idle(3);
        check("frame_count", got.size(), 1);
        if (got.size() > 0) check("frame_digit", {27'd0, got[0]}, 32'd4);
        check("frame_errcnt", {24'd0, err_cnt}, ERRCNT_EN ? 32'd3 : 32'd0);

        // Output stall: hold 7, stream 00101 until its last bit stalls.
        got.delete();
        sif.dout_ready = 1'b0;
        send_word(5'b01001);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        sif.sin = 1'b1;
        sif.sin_sof = 1'b0;
        sif.sin_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        check("stall_ready", {31'd0, sif.sin_ready}, 32'd0);
        check("stall_dout",  {28'd0, sif.dout}, 32'd7);
        sif.dout_ready = 1'b1;
        @(posedge clk);
        #2;
        check("pop_valid", {31'd0, sif.dout_valid}, 32'd0);
        check("pop_ready", {31'd0, sif.sin_ready}, 32'd1);
        @(posedge clk);
        #2;
        check("resume_valid", {31'd0, sif.dout_valid}, 32'd1);
        check("resume_dout",  {28'd0, sif.dout}, 32'd8);
        idle(3);
        check("stall_count", got.size(), 2);
        if (got.size() == 2) begin
            check("stall_first", {27'd0, got[0]}, 32'd7);
            check("stall_second", {27'd0, got[1]}, 32'd8);
        end

        // Unframed bits in HUNT are ignored.
        got.delete();
        sif.sin_valid = 1'b1;
        sif.sin_sof = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sif.sin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end
        check("hunt_none", got.size(), 0);
        check("hunt_errcnt", {24'd0, err_cnt}, ERRCNT_EN ? 32'd3 : 32'd0);
        send_word(5'b00011);
        idle(3);
        check("hunt_count", got.size(), 1);
        if (got.size() > 0) check("hunt_digit", {27'd0, got[0]}, 32'd9);

        // Reset mid-word, then with a word held.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rstw_dout",  {28'd0, sif.dout}, 32'd0);
        check("rstw_ready", {31'd0, sif.sin_ready}, 32'd1);
        check("rstw_err",   {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        idle(1);
        sif.dout_ready = 1'b0;
        send_word(5'b01010);
        check("held_valid", {31'd0, sif.dout_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rstv_valid", {31'd0, sif.dout_valid}, 32'd0);
        check("rstv_dout",  {28'd0, sif.dout}, 32'd0);
        rst = 1'b0;
        sif.dout_ready = 1'b1;
        got.delete();
        send_word(5'b01100);
        idle(3);
        check("post_rst_count", got.size(), 1);
        if (got.size() > 0) check("post_rst_digit", {27'd0, got[0]}, 32'd0);

        // Five invalid words saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) send_word(5'b11100);
        idle(3);
        check("sat_w2",   {30'd0, err_cnt2}, ERRCNT_EN ? 32'd3 : 32'd0);
        check("sat_main", {24'd0, err_cnt}, ERRCNT_EN ? 32'd5 : 32'd0);

        // Randomized traffic: mixed codes, gaps, aborted words, noise, random backpressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [4:0] code;
            int         k;
            code = ($urandom_range(0, 9) < 7) ? legal[$urandom_range(0, 9)] : 5'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                sif.sin_valid = 1'b1;
                sif.sin_sof = 1'b0;
                sif.sin = 1'($urandom_range(0, 1));
                @(posedge clk);
                #2;
            end
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(1, 4);
                for (int b = 0; b < k; b++) send_bit(1'($urandom_range(0, 1)), b == 0);
            end
            send_word(code);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #3;
        sif.dout_ready = 1'b1;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
